// File: rtl/memory_bank_node_pkg.sv
// Shared widths and word types for the node-information store.
package memory_bank_node_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned MEM_DEPTH  = 64;
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH);

  typedef logic [WORD_WIDTH-1:0] node_word_t;
  typedef logic [ADDR_WIDTH-1:0] node_index_t;

endpackage

// File: rtl/memory_bank_node_if.sv
// Access bus between the routing/cluster controller and a node record bank.
interface memory_bank_node_if;
  import memory_bank_node_pkg::*;

  logic        wr_en;
  node_index_t index;
  node_word_t  data_in;
  node_word_t  data_out;

  modport master (
    output wr_en,
    output index,
    output data_in,
    input  data_out
  );

  modport slave (
    input  wr_en,
    input  index,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/memory_bank_node.sv
// Single-port node record bank: registered write, one-cycle registered read
// with write-through on the write edge.
module memory_bank_node #(
  parameter int unsigned WORD_WIDTH = memory_bank_node_pkg::WORD_WIDTH,
  parameter int unsigned MEM_DEPTH  = memory_bank_node_pkg::MEM_DEPTH,
  parameter int unsigned ADDR_WIDTH = memory_bank_node_pkg::ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  memory_bank_node_if.slave bus
);

  logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];
  logic [WORD_WIDTH-1:0] data_q;
  logic                  in_range_c;

  // Indices past the populated depth are write-ignored and read as zero
  assign in_range_c = (32'(bus.index) < MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[ADDR_WIDTH'(i)] <= '0;
      end
      data_q <= '0;
    end else if (bus.wr_en) begin
      if (in_range_c) begin
        mem[bus.index] <= bus.data_in;
      end
      data_q <= bus.data_in;
    end else begin
      data_q <= in_range_c ? mem[bus.index] : '0;
    end
  end

  assign bus.data_out = data_q;

endmodule

// File: tb/tb_memory_bank_node.sv
// Self-checking bench for memory_bank_node: directed vector table then a
// randomized run against a reference array, both through a result queue.
module tb_memory_bank_node;
  import memory_bank_node_pkg::*;

  logic clk = 1'b0;
  logic rst;

  memory_bank_node_if bus ();

  memory_bank_node dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        wr_en;
    node_index_t index;
    node_word_t  data_in;
    node_word_t  exp;
  } vec_t;

  vec_t       vecs[$];
  node_word_t exp_q[$];
  string      name_q[$];
  node_word_t model [MEM_DEPTH];
  int         checks = 0;
  int         errors = 0;

  function automatic void add(string name, logic r, logic we, node_index_t idx,
                              node_word_t din, node_word_t exp);
    vec_t v;
    v.name = name; v.rst = r; v.wr_en = we; v.index = idx;
    v.data_in = din; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Drive one edge worth of inputs, queue the expected output, then compare
  task automatic step(string name, logic r, logic we, node_index_t idx,
                      node_word_t din, node_word_t exp);
    node_word_t want;
    string      nm;
    @(negedge clk);
    rst         = r;
    bus.wr_en   = we;
    bus.index   = idx;
    bus.data_in = din;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, data_out=%h", name, bus.data_out);
    end else begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      if (bus.data_out !== want) begin
        errors++;
        $display("FAIL %s: data_out=%h expected=%h", nm, bus.data_out, want);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.index   = '0;
    bus.data_in = '0;

    add("reset_state",     1, 0, 6'd0,  16'h0000, 16'h0000);
    add("pre_rst_wr5",     0, 1, 6'd5,  16'hBEEF, 16'hBEEF);
    add("rst_edge1",       1, 0, 6'd5,  16'h0000, 16'h0000);
    add("rst_edge2",       1, 0, 6'd5,  16'h0000, 16'h0000);
    add("post_rst_rd5",    0, 0, 6'd5,  16'h0000, 16'h0000);
    add("post_rst_rd0",    0, 0, 6'd0,  16'h0000, 16'h0000);
    add("wr0_through",     0, 1, 6'd0,  16'd3,    16'd3);
    add("rd0",             0, 0, 6'd0,  16'h0000, 16'd3);
    add("wr2_through",     0, 1, 6'd2,  16'd15,   16'd15);
    add("wr4_through",     0, 1, 6'd4,  16'd45,   16'd45);
    add("rd0_seq",         0, 0, 6'd0,  16'h0000, 16'd3);
    add("rd2_seq",         0, 0, 6'd2,  16'h0000, 16'd15);
    add("rd4_seq",         0, 0, 6'd4,  16'h0000, 16'd45);
    add("idle_toggle_a",   0, 0, 6'd2,  16'hAAAA, 16'd15);
    add("idle_toggle_b",   0, 0, 6'd2,  16'h5555, 16'd15);
    add("idle_toggle_c",   0, 0, 6'd2,  16'hFFFF, 16'd15);
    add("wr63_ffff",       0, 1, 6'd63, 16'hFFFF, 16'hFFFF);
    add("wr63_1234",       0, 1, 6'd63, 16'h1234, 16'h1234);
    add("rd63_overwrite",  0, 0, 6'd63, 16'h0000, 16'h1234);
    add("rd62_untouched",  0, 0, 6'd62, 16'h0000, 16'h0000);
    add("rd2_after_63",    0, 0, 6'd2,  16'h0000, 16'd15);
    add("rst_vs_wr7",      1, 1, 6'd7,  16'd9,    16'h0000);
    add("rd7_after_rst",   0, 0, 6'd7,  16'h0000, 16'h0000);
    add("rd63_after_rst",  0, 0, 6'd63, 16'h0000, 16'h0000);
    add("rd2_after_rst",   0, 0, 6'd2,  16'h0000, 16'h0000);
    add("post_rst_wr",     0, 1, 6'd7,  16'h00A5, 16'h00A5);
    add("post_rst_rd7",    0, 0, 6'd7,  16'h0000, 16'h00A5);

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst, vecs[i].wr_en, vecs[i].index,
           vecs[i].data_in, vecs[i].exp);

    // Randomized traffic against a reference array, starting from a reset
    foreach (model[i]) model[i] = '0;
    step("rand_rst", 1, 0, 6'd0, 16'h0000, 16'h0000);
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic        we;
      node_index_t idx;
      node_word_t  din;
      node_word_t  exp;
      r   = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 1) == 1);
      idx = node_index_t'($urandom_range(0, 7) == 0 ? $urandom_range(60, 63)
                                                    : $urandom_range(0, 15));
      din = node_word_t'($urandom);
      if (r) begin
        foreach (model[i]) model[i] = '0;
        exp = '0;
      end else if (we) begin
        model[idx] = din;
        exp = din;
      end else begin
        exp = model[idx];
      end
      step("rand", r, we, idx, din, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
